// File: rtl/freq_counter_bcd_pkg.sv
// freq_counter_pkg: shared encodings for the BCD frequency counter
package freq_counter_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10
    } edge_mode_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_sat_counter.sv
// bcd_sat_counter: ripple-carry BCD accumulator that sticks at all 9s and flags saturation
module bcd_sat_counter
    import freq_counter_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      inc,
    output logic [BCD_W*DIGITS-1:0]   value,
    output logic                      sat
);

    logic [BCD_W*DIGITS-1:0] value_q, value_d;
    logic                    sat_q, sat_d;
    logic                    c;

    // value/sat include this cycle's increment so a closing window sees its last edge
    always_comb begin
        c = inc;
        value = value_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) value[BCD_W*i +: BCD_W] = (value_q[BCD_W*i +: BCD_W] == 4'd9) ? '0 : value_q[BCD_W*i +: BCD_W] + 4'd1;
            c = c & (value_q[BCD_W*i +: BCD_W] == 4'd9);
        end
        value = c ? value_q : value;
        sat = sat_q | c;
        value_d = clear ? '0 : value;
        sat_d = clear ? 1'b0 : sat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
            sat_q <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/freq_counter_bcd.sv
// freq_counter_bcd: gated edge counter accumulating in BCD, latched result with valid strobe
module freq_counter_bcd
    import freq_counter_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int PERIOD_BITS    = 16,
    parameter int DEFAULT_PERIOD = 1200,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      signal,
    input  logic                      enable,
    input  logic [1:0]                edge_mode,
    input  logic [PERIOD_BITS-1:0]    period,
    input  logic                      period_load,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      overflow,
    output logic                      valid
);

    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    dly_q, dly_d;
    logic [PERIOD_BITS-1:0]  per_q, per_d, cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [BCD_W*DIGITS-1:0] bcd_q, bcd_d, acc;
    logic                    ovf_q, ovf_d, valid_q, valid_d;
    logic                    rise, fall, hit, run, close, acc_sat;

    bcd_sat_counter #(.DIGITS(DIGITS)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run || close),
        .inc     (run && hit),
        .value   (acc),
        .sat     (acc_sat)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal};
        dly_d = sync_q[SYNC_STAGES-1];
        rise = sync_q[SYNC_STAGES-1] & ~dly_q;
        fall = ~sync_q[SYNC_STAGES-1] & dly_q;
        hit = (edge_mode == EDGE_FALL) ? fall : (edge_mode == EDGE_BOTH) ? (rise | fall) : rise;
        per_d = period_load ? period : per_q;
        // dropping enable mid-window discards it rather than closing it
        run = (state_q == S_COUNT) && enable;
        close = run && (cnt_q >= per_q);
        state_d = enable ? S_COUNT : S_IDLE;
        cnt_d = (run && !close) ? cnt_q + PERIOD_BITS'(1) : '0;
        bcd_d = close ? acc : bcd_q;
        ovf_d = close ? acc_sat : ovf_q;
        valid_d = close;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q <= 1'b0;
            per_q <= PERIOD_BITS'(DEFAULT_PERIOD);
            cnt_q <= '0;
            state_q <= S_IDLE;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q <= dly_d;
            per_q <= per_d;
            cnt_q <= cnt_d;
            state_q <= state_d;
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bcd = bcd_q;
    assign overflow = ovf_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_freq_counter_bcd.sv
// tb_freq_counter_bcd: table-driven, directed and random checks against an integer-count model
module tb_freq_counter_bcd;

    localparam int D    = 3;
    localparam int S    = 2;
    localparam int MAXV = 999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        signal = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  edge_mode = 2'b00;
    logic [15:0] period = '0;
    logic        period_load = 1'b0;
    logic [11:0] bcd;
    logic        overflow, valid;

    freq_counter_bcd #(.DIGITS(D), .PERIOD_BITS(16), .DEFAULT_PERIOD(1200), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .signal      (signal),
        .enable      (enable),
        .edge_mode   (edge_mode),
        .period      (period),
        .period_load (period_load),
        .bcd         (bcd),
        .overflow    (overflow),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, cyc = 0;

    bit sq [0:S];
    bit m_count, m_sat, e_ovf, e_valid;
    int m_cnt, m_acc, m_per, e_bcd;

    typedef struct {
        int mode; int n; int h; int per; int reload; int exp_bcd; int exp_ovf;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= S; i++) sq[i] = 1'b0;
        m_count = 0; m_sat = 0; m_cnt = 0; m_acc = 0; m_per = 1200;
        e_bcd = 0; e_ovf = 0; e_valid = 0;
    endtask

    task automatic model_edge();
        bit r, f, ed;
        int a;
        if (!reset_n) begin
            model_reset();
            return;
        end
        r = sq[S-1] && !sq[S];
        f = !sq[S-1] && sq[S];
        ed = (edge_mode == 2'b01) ? f : (edge_mode == 2'b10) ? (r | f) : r;
        e_valid = 0;
        if (m_count && enable) begin
            a = m_acc + int'(ed);
            if (a > MAXV) begin
                a = MAXV;
                m_sat = 1;
            end
            if (m_cnt >= m_per) begin
                e_bcd = a; e_ovf = m_sat; e_valid = 1;
                m_cnt = 0; m_acc = 0; m_sat = 0;
            end else begin
                m_cnt++;
                m_acc = a;
            end
        end else begin
            m_count = enable;
            m_cnt = 0; m_acc = 0; m_sat = 0;
        end
        if (period_load) m_per = int'(period);
        for (int i = S; i > 0; i--) sq[i] = sq[i-1];
        sq[0] = signal;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        vecs++;
        if (bcd !== to_bcd(e_bcd) || overflow !== e_ovf || valid !== e_valid) begin
            errs++;
            $display("FAIL model cycle %0d: bcd=%h ovf=%b valid=%b expected bcd=%h ovf=%b valid=%b",
                     cyc, bcd, overflow, valid, to_bcd(e_bcd), e_ovf, e_valid);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic pulses(input int n, input int h);
        repeat (n) begin
            signal = 1'b1; steps(h);
            signal = 1'b0; steps(h);
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < maxc);
        if (!valid) chk("valid_timeout", int'(valid), 1);
    endtask

    task automatic load_period(input int p);
        period = 16'(p);
        period_load = 1'b1;
        step();
        period_load = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_valid", int'(valid), 0);
        for (int i = 0; i < 4; i++) begin
            signal = ~signal;
            step();
        end
        signal = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int t0;
        model_reset();
        tbl[0] = '{0,   37, 10, 1200,   0, 'h037, 0};
        tbl[1] = '{2,   37, 10, 1200,   0, 'h074, 0};
        tbl[2] = '{1,   12,  3,  100,   0, 'h012, 0};
        tbl[3] = '{3,    9,  2,  100,   0, 'h009, 0};
        tbl[4] = '{0, 1005,  2, 20000, 100, 'h999, 1};
        steps(3);
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 5; k++) begin
            enable = 1'b0;
            do_reset();
            if (tbl[k].per != 1200) load_period(tbl[k].per);
            edge_mode = 2'(tbl[k].mode);
            enable = 1'b1;
            step();
            t0 = cyc;
            pulses(tbl[k].n, tbl[k].h);
            if (tbl[k].reload != 0) begin
                steps(4);
                load_period(tbl[k].reload);
                step();
                chk("reload_close", int'(valid), 1);
            end else begin
                wait_valid(25000);
                chk("window_len", cyc - t0, tbl[k].per + 1);
            end
            chk("tbl_bcd", int'(bcd), tbl[k].exp_bcd);
            chk("tbl_ovf", int'(overflow), tbl[k].exp_ovf);
        end
        edge_mode = 2'b00;
        pulses(5, 2);
        wait_valid(500);
        chk("post_sat_bcd", int'(bcd), 'h005);
        chk("post_sat_ovf", int'(overflow), 0);

        enable = 1'b0;
        do_reset();
        load_period(50);
        enable = 1'b1;
        step();
        t0 = cyc;
        steps(48);
        signal = 1'b1;
        wait_valid(100);
        chk("boundary_len", cyc - t0, 51);
        chk("boundary_bcd", int'(bcd), 'h001);
        wait_valid(100);
        chk("boundary_next", int'(bcd), 'h000);

        enable = 1'b0;
        signal = 1'b0;
        do_reset();
        enable = 1'b1;
        step();
        pulses(4, 5);
        wait_valid(2000);
        chk("en_first_bcd", int'(bcd), 'h004);
        pulses(6, 5);
        steps(240);
        enable = 1'b0;
        steps(200);
        chk("en_hold_bcd", int'(bcd), 'h004);
        chk("en_hold_valid", int'(valid), 0);
        enable = 1'b1;
        step();
        t0 = cyc;
        pulses(3, 5);
        wait_valid(2000);
        chk("reen_len", cyc - t0, 1201);
        chk("reen_bcd", int'(bcd), 'h003);
        pulses(8, 5);
        steps(520);
        do_reset();
        step();
        t0 = cyc;
        wait_valid(2000);
        chk("post_rst_len", cyc - t0, 1201);
        chk("post_rst_bcd", int'(bcd), 'h000);

        step();
        t0 = cyc;
        pulses(7, 5);
        steps(430);
        period = 16'd100;
        period_load = 1'b1;
        step();
        period_load = 1'b0;
        step();
        chk("pchg_valid", int'(valid), 1);
        chk("pchg_bcd", int'(bcd), 'h007);
        t0 = cyc;
        wait_valid(300);
        chk("pchg_len", cyc - t0, 101);

        load_period(0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p0_valid", int'(valid), 1);
        end

        load_period(60);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) signal = ~signal;
            if ($urandom_range(0, 199) == 0) edge_mode = 2'($urandom_range(0, 3));
            period_load = ($urandom_range(0, 299) == 0);
            period = 16'($urandom_range(0, 150));
            if (enable ? ($urandom_range(0, 499) == 0) : ($urandom_range(0, 9) == 0)) enable = ~enable;
            step();
        end
        period_load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/freq_counter_bcd.md
Name: freq_counter_bcd

Overview:
- Parametrised successor to the two-digit frequency counter.
- Counts input edges over a programmable gate window of clk cycles, accumulating directly in BCD across DIGITS digits. No post-window subtraction pass.
- Edge polarity is selectable, the count saturates with an overflow flag, and each window result is presented as a latched BCD bus with a one-cycle valid strobe.
- Sits between the synchronised signal input and the display or readout logic.

Parameters:
- DIGITS, 3, number of BCD digits in the accumulator and output (1..8).
- PERIOD_BITS, 16, width of the gate-window period register.
- DEFAULT_PERIOD, 1200, gate period loaded at reset.
- SYNC_STAGES, 2, synchroniser flops on signal (>=2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- signal  input  1  asynchronous measured input.
- enable  input  1  1 = run gate windows; 0 = hold window logic idle.
- edge_mode  input  2  00 rising, 01 falling, 10 both, 11 rising.
- period  input  PERIOD_BITS  new gate period.
- period_load  input  1  load period into the period register this cycle.
- bcd  output  4*DIGITS  latched count; digit 0 is bits [3:0] (units).
- overflow  output  1  latched: count saturated in the reported window.
- valid  output  1  one-cycle pulse; bcd/overflow updated.

Behaviour:
- Reset (async assert, sync release):
  - bcd=0, overflow=0, valid=0.
  - Accumulator=0, window counter=0, period register=DEFAULT_PERIOD.
  - Synchroniser and edge-delay flops cleared to 0.
- Synchroniser and edge detect:
  - signal passes through SYNC_STAGES flops, then one delay flop; edges are detected between the last sync flop and the delay flop.
  - A transition sampled at clk edge k is counted in the accumulator at edge k+SYNC_STAGES.
  - edge_mode is sampled every cycle with no synchronisation requirement. In mode 10 each pulse counts 2.
- Period register:
  - period_load=1 writes period at the next edge; it is not gated by enable.
  - Takes effect immediately for the comparison below. Window progress is not restarted.
- Window state machine, two states:
  - IDLE (enable=0): window counter and accumulator held at 0, valid=0. When enable is 1, go to COUNT next cycle.
  - COUNT, every cycle:
    - window counter +1.
    - If an edge is detected, accumulator BCD-increments by 1.
  - Window close: when window counter >= period register.
    - The accumulator value including any edge detected that same cycle is latched into bcd, along with the sticky sat flag into overflow.
    - valid=1 for exactly the following cycle.
    - Window counter, accumulator and sat clear; the next window begins the cycle after close.
  - Window length is period+1 cycles. period=0 closes every cycle.
  - If period is lowered below the current count, the window closes on the next cycle.
  - If enable drops during COUNT, go to IDLE at the next edge: the partial window is discarded, no valid, bcd retained.
- BCD arithmetic:
  - Per-digit ripple carry: a digit at 9 wraps to 0 and carries.
  - With all digits at 9, a further edge leaves the accumulator at all 9s and sets sat.
  - No binary counter of edges exists.
- Outputs:
  - bcd and overflow change only at window close.
  - valid is never asserted two consecutive cycles unless period=0.
- Reset mid-window: all state clears asynchronously; no valid is generated for the partial window.

Decomposition:
- Shared package freq_counter_pkg holds:
  - edge_mode encodings EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - state encodings S_IDLE, S_COUNT;
  - BCD digit width 4.
- One sub-module, bcd_sat_counter:
  - ports: clk, reset_n, clear, inc; outputs value and sat;
  - DIGITS parameter;
  - ripple BCD increment with saturation.
- The top level holds the synchroniser, edge detect, period register and window FSM.

Test Plan:
- Reset: hold reset_n=0 with signal toggling -> bcd=000, overflow=0, valid=0. After release with enable=1, the first valid occurs exactly 1201 cycles after COUNT entry, with DEFAULT_PERIOD=1200.
- Rising mode: 37 clean pulses (10 cycles high, 10 low) inside a 1201-cycle window -> bcd=0x037, overflow=0, single valid pulse. Repeating with edge_mode=10 -> bcd=0x074.
- Saturation, DIGITS=3: period=20000, drive 1005 rising edges -> bcd=0x999, overflow=1. The next window with 5 edges -> bcd=0x005, overflow=0.
- Boundary edge: place a detected edge on the closing cycle -> it is counted in that window's bcd, not the next.
- Period change: after 500 cycles, load period=100 -> window closes the next cycle with the count so far. Subsequent windows are 101 cycles.
- Control and reset mid-window:
  - enable=0 at cycle 300 -> no valid, bcd unchanged; re-enable -> fresh full window.
  - reset_n pulse at cycle 600 -> all outputs 0 immediately, no valid for the partial window.
